// File: rtl/mdu_pkg.sv
// Shared encodings and sizing for the iterative multiply/divide unit.
// The op encodings follow the ID-stage decode of mult/multu/div/divu.
package mdu_pkg;

  localparam int MDU_W     = 32;
  localparam int MDU_CNTW  = 6;
  localparam int MDU_STEPS = 32;

  typedef enum logic [1:0] {
    MDU_MULTU = 2'b00,
    MDU_MULT  = 2'b01,
    MDU_DIVU  = 2'b10,
    MDU_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

endpackage

// File: rtl/mdu_step.sv
// One (W+1)-bit add or subtract with carry-out, shared by the multiply
// partial-product add and the divide trial subtract.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int W = MDU_W
) (
  input  logic [W:0] i_x,
  input  logic [W:0] i_y,
  input  logic       i_sub,
  output logic [W:0] o_sum,
  output logic       o_cout
);

  logic [W+1:0] w_full;

  // For subtract, carry-out set means no borrow, i.e. i_x >= i_y.
  assign w_full = {1'b0, i_x} + {1'b0, (i_sub ? ~i_y : i_y)} + {{(W+1){1'b0}}, i_sub};
  assign o_sum  = w_full[W:0];
  assign o_cout = w_full[W+1];

endmodule

// File: rtl/pipe_mdu_ctrl.sv
// Iterative multiply/divide unit beside EX: 32-step shift-add / restoring
// divide sequencer, HI/LO registers and the stall request back to ID.
module pipe_mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int W    = MDU_W,
  parameter int CNTW = MDU_CNTW
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         rd_hi,
  input  logic         rd_lo,
  input  logic         wr_hi,
  input  logic         wr_lo,
  input  logic [W-1:0] wdata,
  output logic         stall,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  state_e          r_state, w_next;
  logic [CNTW-1:0] r_cnt;
  logic [2*W-1:0]  r_acc;
  logic [W-1:0]    r_opnd;
  logic            r_neg_q, r_neg_r, r_is_div, r_done;
  logic [W-1:0]    r_hi, r_lo;

  logic            w_signed, w_a_neg, w_b_neg;
  logic [W-1:0]    w_a_mag, w_b_mag;
  logic [W:0]      w_x, w_y, w_sum;
  logic            w_cout;
  logic [2*W-1:0]  w_acc_step, w_prod_neg;

  assign w_signed = (op == MDU_MULT) || (op == MDU_DIV);
  assign w_a_neg  = w_signed & a[W-1];
  assign w_b_neg  = w_signed & b[W-1];
  assign w_a_mag  = w_a_neg ? -a : a;
  assign w_b_mag  = w_b_neg ? -b : b;

  // Divide feeds the shifted remainder including the bit pushed out of the top.
  assign w_x = r_is_div ? r_acc[2*W-1:W-1] : {1'b0, r_acc[2*W-1:W]};
  assign w_y = {1'b0, r_opnd};

  mdu_step #(.W(W)) u_step (
    .i_x    (w_x),
    .i_y    (w_y),
    .i_sub  (r_is_div),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_acc_step = r_acc;
    if (r_is_div)
      w_acc_step = w_cout ? {w_sum[W-1:0], r_acc[W-2:0], 1'b1} : {r_acc[2*W-2:0], 1'b0};
    else
      w_acc_step = r_acc[0] ? {w_sum, r_acc[W-1:1]} : {1'b0, r_acc[2*W-1:1]};
  end

  assign w_prod_neg = -r_acc;

  // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == CNTW'(1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_opnd   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= (r_state == S_FIX);
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_cnt    <= CNTW'(MDU_STEPS);
            r_acc    <= {{W{1'b0}}, (op[1] ? w_a_mag : w_b_mag)};
            r_opnd   <= op[1] ? w_b_mag : w_a_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_is_div <= op[1];
          end else begin
            if (wr_hi) r_hi <= wdata;
            if (wr_lo) r_lo <= wdata;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - CNTW'(1);
          r_acc <= w_acc_step;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_lo <= r_neg_q ? -r_acc[W-1:0]   : r_acc[W-1:0];
            r_hi <= r_neg_r ? -r_acc[2*W-1:W] : r_acc[2*W-1:W];
          end else begin
            {r_hi, r_lo} <= r_neg_q ? w_prod_neg : r_acc;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign stall = busy & (start | rd_hi | rd_lo | wr_hi | wr_lo);
  assign done  = r_done;
  assign hi    = r_hi;
  assign lo    = r_lo;

endmodule

// File: tb/tb_pipe_mdu_ctrl.sv
// Directed bench for pipe_mdu_ctrl: expected HI/LO pushed to a scoreboard
// when an op is issued and popped when the done pulse appears.
module tb_pipe_mdu_ctrl;
  import mdu_pkg::*;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic        clock, resetn, start, rd_hi, rd_lo, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        stall, busy, done;
  logic [31:0] hi, lo;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [31:0] m_hi, m_lo;

  pipe_mdu_ctrl dut (
    .clock (clock), .resetn (resetn), .start (start), .op (op),
    .a (a), .b (b), .rd_hi (rd_hi), .rd_lo (rd_lo), .wr_hi (wr_hi),
    .wr_lo (wr_lo), .wdata (wdata), .stall (stall), .busy (busy),
    .done (done), .hi (hi), .lo (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    longint sx, sy, p, q, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    e  = '0;
    case (o)
      MDU_MULTU: begin u = {32'b0, x} * {32'b0, y}; e.hi = u[63:32]; e.lo = u[31:0]; end
      MDU_MULT:  begin p = sx * sy; u = p; e.hi = u[63:32]; e.lo = u[31:0]; end
      MDU_DIVU: begin
        if (y == 0) begin e.hi = x; e.lo = 32'hFFFFFFFF; end
        else begin e.hi = x % y; e.lo = x / y; end
      end
      default: begin
        if (y == 0) begin e.hi = x; e.lo = 32'hFFFFFFFF; end
        else begin
          q = sx / sy; r = sx % sy;
          u = q; e.lo = u[31:0];
          u = r; e.hi = u[31:0];
        end
      end
    endcase
    return e;
  endfunction

  task automatic push_exp(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh; e.lo = el;
    sb.push_back(e);
  endtask

  // Issue one op, optionally hold rd_lo and poke start mid-run, then check the result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic hold_rd, input int poke);
    int   cycles;
    int   stall_bad;
    logic hold_bad;
    exp_t e;
    @(negedge clock);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    cycles = 0; stall_bad = 0; hold_bad = 1'b0;
    while (busy === 1'b1 && cycles < 100) begin
      rd_lo = hold_rd;
      start = (cycles == poke);
      if (start) begin op = MDU_MULTU; a = 32'd3; b = 32'd3; end
      #1;
      if (stall !== (rd_lo | start)) stall_bad++;
      if (cycles == 10 && (hi !== m_hi || lo !== m_lo)) hold_bad = 1'b1;
      cycles++;
      @(negedge clock);
      start = 1'b0;
    end
    #1;
    check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
    check({tag, "_hold"}, {63'd0, hold_bad}, 64'd0);
    check({tag, "_stall_done"}, {63'd0, stall}, 64'd0);
    check({tag, "_busy_cycles"}, 64'(cycles), 64'd33);
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    rd_lo = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({tag, "_hilo"}, {hi, lo}, {e.hi, e.lo});
      m_hi = e.hi; m_lo = e.lo;
    end
    @(negedge clock);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    exp_t e;
    int   done_seen;
    logic [1:0] ro;
    logic [31:0] ra, rb;
    start = 0; op = 0; a = 0; b = 0; rd_hi = 0; rd_lo = 0;
    wr_hi = 0; wr_lo = 0; wdata = 0; resetn = 1'b0;
    m_hi = 0; m_lo = 0;
    #1;
    check("reset_state", {busy, stall, done, hi, lo}, '0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    push_exp(32'd0, 32'd42);
    run_op("multu_7x6", MDU_MULTU, 32'd7, 32'd6, 1'b0, -1);
    push_exp(32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("mult_m3x5", MDU_MULT, 32'hFFFFFFFD, 32'd5, 1'b0, -1);
    push_exp(32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_m7_2", MDU_DIV, 32'hFFFFFFF9, 32'd2, 1'b0, -1);
    push_exp(32'd15, 32'h0FFFFFFF);
    run_op("divu_big_16", MDU_DIVU, 32'hFFFFFFFF, 32'd16, 1'b0, -1);
    push_exp(32'd9, 32'hFFFFFFFF);
    run_op("divu_by0", MDU_DIVU, 32'd9, 32'd0, 1'b0, -1);
    push_exp(32'd0, 32'h80000000);
    run_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1);

    e = model(MDU_MULT, 32'hFFFF1234, 32'h00ABCDEF);
    sb.push_back(e);
    run_op("mult_rdlo_stall", MDU_MULT, 32'hFFFF1234, 32'h00ABCDEF, 1'b1, -1);
    e = model(MDU_MULTU, 32'hDEADBEEF, 32'h12345678);
    sb.push_back(e);
    run_op("multu_restart_ignored", MDU_MULTU, 32'hDEADBEEF, 32'h12345678, 1'b0, 5);

    for (int i = 0; i < 4; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom | 32'd1;
      e  = model(ro, ra, rb);
      sb.push_back(e);
      run_op($sformatf("rand%0d", i), ro, ra, rb, 1'b0, -1);
    end

    // Abort mid-op with reset: no done pulse, HI/LO cleared.
    @(negedge clock);
    start = 1'b1; op = MDU_MULT; a = 32'd100; b = 32'd200;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    resetn = 1'b0;
    #1;
    check("abort_state", {busy, done, hi, lo}, '0);
    @(negedge clock);
    resetn = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    m_hi = 0; m_lo = 0;

    // mthi / mtlo while idle.
    @(negedge clock);
    wr_hi = 1'b1; wdata = 32'h1234;
    #1;
    check("mthi_no_stall", {63'd0, stall}, 64'd0);
    @(negedge clock);
    wr_hi = 1'b0; wr_lo = 1'b1; wdata = 32'hCAFEF00D;
    #1;
    check("mthi_hi", {32'd0, hi}, {32'd0, 32'h1234});
    @(negedge clock);
    wr_lo = 1'b0;
    check("mtlo_hilo", {hi, lo}, {32'h1234, 32'hCAFEF00D});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
